// File: rtl/p2s_shift_register_pkg.sv
// Shared types and constants for the parallel-to-serial output stage.
// Shifter state codes, default bit rate and bit-order helpers.
package p2s_shift_register_pkg;

   localparam int BYTE_WIDTH = 8;
   localparam int DEFAULT_CLOCK_DIVIDE = 50;

   typedef enum logic [1:0] {
      Idle      = 2'd0,
      ClockLow  = 2'd1,
      ClockHigh = 2'd2
   } state_t;

   function automatic logic first_bit(
      input logic [BYTE_WIDTH-1:0] b,
      input logic lsb_first
   );
      return lsb_first ? b[0] : b[BYTE_WIDTH-1];
   endfunction

   function automatic logic [BYTE_WIDTH-1:0] shift_byte(
      input logic [BYTE_WIDTH-1:0] b,
      input logic lsb_first
   );
      return lsb_first ? {1'b0, b[BYTE_WIDTH-1:1]}
                       : {b[BYTE_WIDTH-2:0], 1'b0};
   endfunction

endpackage

// File: rtl/p2s_shift_register_if.sv
// Byte load handshake and serial output bundle.
// master = message sender side, slave = shift register.
interface p2s_shift_register_if;
   import p2s_shift_register_pkg::*;

   logic                  Load;
   logic [BYTE_WIDTH-1:0] InputByte;
   logic                  Empty;
   logic                  SerialClock;
   logic                  SerialData;
   logic                  Busy;
   logic                  Overrun;

   modport master (
      output Load, InputByte,
      input  Empty, SerialClock, SerialData, Busy, Overrun
   );

   modport slave (
      input  Load, InputByte,
      output Empty, SerialClock, SerialData, Busy, Overrun
   );

endinterface

// File: rtl/p2s_shift_register_half_bit_timer.sv
// Half-bit-period timer: counts from 0 after restart, Tick at ClockDivide-1.
module half_bit_timer #(
   parameter int ClockDivide = 50
) (
   input  logic Clock,
   input  logic Clear,
   input  logic restart,
   output logic Tick
);

   localparam logic [15:0] LAST = 16'(ClockDivide - 1);

   logic [15:0] halfCount;

   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) halfCount <= '0;
      else if (restart) halfCount <= '0;
      else halfCount <= halfCount + 16'd1;
   end

   assign Tick = (halfCount == LAST);

endmodule

// File: rtl/p2s_shift_register.sv
// Double-buffered parallel-to-serial shifter driving SerialClock/SerialData.
module p2s_shift_register
   import p2s_shift_register_pkg::*;
#(
   parameter int ClockDivide = DEFAULT_CLOCK_DIVIDE,
   parameter bit LSBFirst    = 1'b0
) (
   input  logic Clock,
   input  logic Clear,
   p2s_shift_register_if.slave bus
);

   state_t                state, state_n;
   logic [BYTE_WIDTH-1:0] holdReg, shiftReg, shiftReg_n;
   logic                  holdFull, holdFull_n;
   logic [3:0]            bitsLeft, bitsLeft_n;
   logic                  sclk, sclk_n;
   logic                  sdata, sdata_n;
   logic                  overrun;
   logic                  transfer;
   logic                  restart;
   logic                  tick;
   logic                  accept;

   half_bit_timer #(.ClockDivide(ClockDivide)) u_timer (
      .Clock   (Clock),
      .Clear   (Clear),
      .restart (restart),
      .Tick    (tick)
   );

   assign accept = bus.Load & ~holdFull;

   always_comb begin
      state_n    = state;
      shiftReg_n = shiftReg;
      bitsLeft_n = bitsLeft;
      sdata_n    = sdata;
      transfer   = 1'b0;
      restart    = 1'b0;
      case (state)
         Idle: begin
            restart  = 1'b1;
            transfer = holdFull;
         end
         ClockLow: begin
            if (tick) begin
               restart = 1'b1;
               state_n = ClockHigh;
            end
         end
         ClockHigh: begin
            if (tick) begin
               restart    = 1'b1;
               bitsLeft_n = bitsLeft - 4'd1;
               if (bitsLeft > 4'd1) begin
                  shiftReg_n = shift_byte(shiftReg, LSBFirst);
                  sdata_n    = first_bit(shiftReg_n, LSBFirst);
                  state_n    = ClockLow;
               end else if (holdFull) begin
                  transfer = 1'b1;
               end else begin
                  state_n = Idle;
               end
            end
         end
         default: begin
            restart = 1'b1;
            state_n = Idle;
         end
      endcase
      // Transfer also covers the back-to-back case at the end of a byte.
      if (transfer) begin
         shiftReg_n = holdReg;
         bitsLeft_n = 4'd8;
         sdata_n    = first_bit(holdReg, LSBFirst);
         state_n    = ClockLow;
         restart    = 1'b1;
      end
      holdFull_n = accept ? 1'b1 : (transfer ? 1'b0 : holdFull);
      sclk_n     = (state_n == ClockHigh);
   end

   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state    <= Idle;
         holdReg  <= '0;
         holdFull <= 1'b0;
         shiftReg <= '0;
         bitsLeft <= '0;
         sclk     <= 1'b0;
         sdata    <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_n;
         holdFull <= holdFull_n;
         shiftReg <= shiftReg_n;
         bitsLeft <= bitsLeft_n;
         sclk     <= sclk_n;
         sdata    <= sdata_n;
         if (accept) holdReg <= bus.InputByte;
         if (bus.Load & holdFull) overrun <= 1'b1;
      end
   end

   assign bus.Empty       = ~holdFull;
   assign bus.SerialClock = sclk;
   assign bus.SerialData  = sdata;
   assign bus.Busy        = holdFull | (state != Idle);
   assign bus.Overrun     = overrun;

endmodule

// File: tb/tb_p2s_shift_register.sv
// Directed bench for p2s_shift_register (MSB/CD=2 and LSB/CD=1 instances).
module tb_p2s_shift_register;

   logic Clock = 1'b0;
   logic Clear = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   p2s_shift_register_if bus_a ();
   p2s_shift_register_if bus_b ();

   p2s_shift_register #(.ClockDivide(2), .LSBFirst(1'b0)) dut_a (
      .Clock (Clock),
      .Clear (Clear),
      .bus   (bus_a.slave)
   );

   p2s_shift_register #(.ClockDivide(1), .LSBFirst(1'b1)) dut_b (
      .Clock (Clock),
      .Clear (Clear),
      .bus   (bus_b.slave)
   );

   // Receiver model: sample SerialData on each SerialClock rise.
   logic [63:0] bits_a = '0;
   logic [63:0] bits_b = '0;
   int          na = 0;
   int          nb = 0;
   logic        prev_a = 1'b0;
   logic        prev_b = 1'b0;
   int          rise_t [0:255];

   always @(negedge Clock) begin
      prev_a <= bus_a.SerialClock;
      if (bus_a.SerialClock === 1'b1 && prev_a === 1'b0) begin
         bits_a <= {bits_a[62:0], bus_a.SerialData};
         rise_t[na % 256] <= cyc;
         na <= na + 1;
      end
   end

   always @(negedge Clock) begin
      prev_b <= bus_b.SerialClock;
      if (bus_b.SerialClock === 1'b1 && prev_b === 1'b0) begin
         bits_b <= {bits_b[62:0], bus_b.SerialData};
         nb <= nb + 1;
      end
   end

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_a(logic [7:0] b);
      bus_a.Load = 1'b1;
      bus_a.InputByte = b;
      @(negedge Clock);
      bus_a.Load = 1'b0;
   endtask

   task automatic load_b(logic [7:0] b);
      bus_b.Load = 1'b1;
      bus_b.InputByte = b;
      @(negedge Clock);
      bus_b.Load = 1'b0;
   endtask

   task automatic wait_a_empty(string tag);
      int n = 0;
      while (bus_a.Empty !== 1'b1 && n < 200) begin
         @(negedge Clock);
         n++;
      end
      chk(tag, 64'(n < 200), 64'd1);
   endtask

   task automatic wait_a_idle(string tag);
      int n = 0;
      while (bus_a.Busy !== 1'b0 && n < 600) begin
         @(negedge Clock);
         n++;
      end
      chk(tag, 64'(n < 600), 64'd1);
   endtask

   initial begin
      int n0;
      int tcyc;
      int k;
      int bad;
      logic [7:0] msg [0:5];
      msg[0] = 8'hDE; msg[1] = 8'hAD; msg[2] = 8'hBE;
      msg[3] = 8'hEF; msg[4] = 8'h01; msg[5] = 8'h02;
      bus_a.Load = 1'b0;
      bus_a.InputByte = '0;
      bus_b.Load = 1'b0;
      bus_b.InputByte = '0;

      // Reset values
      repeat (2) @(negedge Clock);
      chk("rst_empty", 64'(bus_a.Empty), 64'd1);
      chk("rst_sclk", 64'(bus_a.SerialClock), 64'd0);
      chk("rst_sdata", 64'(bus_a.SerialData), 64'd0);
      chk("rst_busy", 64'(bus_a.Busy), 64'd0);
      chk("rst_ovr", 64'(bus_a.Overrun), 64'd0);
      Clear = 1'b0;
      @(negedge Clock);

      // Single byte A5, MSB first, CD=2
      n0 = na;
      load_a(8'hA5);
      chk("a5_empty_lo", 64'(bus_a.Empty), 64'd0);
      @(negedge Clock);
      tcyc = cyc;
      chk("a5_empty_hi", 64'(bus_a.Empty), 64'd1);
      chk("a5_busy", 64'(bus_a.Busy), 64'd1);
      repeat (31) @(negedge Clock);
      chk("a5_busy_31", 64'(bus_a.Busy), 64'd1);
      @(negedge Clock);
      chk("a5_busy_32", 64'(bus_a.Busy), 64'd0);
      chk("a5_nbits", 64'(na - n0), 64'd8);
      chk("a5_bits", 64'(bits_a[7:0]), 64'hA5);
      chk("a5_first_rise", 64'(rise_t[n0 % 256] - tcyc), 64'd2);
      chk("a5_idle_sclk", 64'(bus_a.SerialClock), 64'd0);
      chk("a5_idle_sdata", 64'(bus_a.SerialData), 64'd1);

      // Back-to-back 3C, C3
      n0 = na;
      load_a(8'h3C);
      wait_a_empty("b2b_wait_empty");
      load_a(8'hC3);
      wait_a_idle("b2b_wait_idle");
      chk("b2b_nbits", 64'(na - n0), 64'd16);
      chk("b2b_bits", 64'(bits_a[15:0]), 64'h3CC3);
      bad = 0;
      for (int i = 1; i < 16; i++)
         if (rise_t[(n0 + i) % 256] - rise_t[(n0 + i - 1) % 256] != 4)
            bad++;
      chk("b2b_gap", 64'(bad), 64'd0);
      chk("b2b_ovr", 64'(bus_a.Overrun), 64'd0);

      // Overrun: 11, 22, then 33 while full
      n0 = na;
      load_a(8'h11);
      wait_a_empty("ovr_wait_empty");
      load_a(8'h22);
      chk("ovr_pre", 64'(bus_a.Overrun), 64'd0);
      load_a(8'h33);
      chk("ovr_set", 64'(bus_a.Overrun), 64'd1);
      wait_a_idle("ovr_wait_idle");
      chk("ovr_nbits", 64'(na - n0), 64'd16);
      chk("ovr_bits", 64'(bits_a[15:0]), 64'h1122);
      chk("ovr_sticky", 64'(bus_a.Overrun), 64'd1);

      // Asynchronous Clear mid-byte
      n0 = na;
      load_a(8'hFF);
      k = 0;
      while (na - n0 < 3 && k < 100) begin
         @(negedge Clock);
         k++;
      end
      chk("clr_wait_rise", 64'(k < 100), 64'd1);
      #2 Clear = 1'b1;
      #1;
      chk("clr_sclk", 64'(bus_a.SerialClock), 64'd0);
      chk("clr_sdata", 64'(bus_a.SerialData), 64'd0);
      chk("clr_busy", 64'(bus_a.Busy), 64'd0);
      chk("clr_empty", 64'(bus_a.Empty), 64'd1);
      chk("clr_ovr", 64'(bus_a.Overrun), 64'd0);
      @(negedge Clock);
      Clear = 1'b0;
      @(negedge Clock);
      n0 = na;
      load_a(8'h81);
      wait_a_idle("clr_wait_idle");
      chk("clr_nbits", 64'(na - n0), 64'd8);
      chk("clr_bits", 64'(bits_a[7:0]), 64'h81);

      // LSB first, CD=1
      n0 = nb;
      load_b(8'h01);
      @(negedge Clock);
      k = 0;
      while (bus_b.Busy !== 1'b0 && k < 100) begin
         @(negedge Clock);
         k++;
      end
      chk("lsb_bytetime", 64'(k), 64'd16);
      chk("lsb_nbits", 64'(nb - n0), 64'd8);
      chk("lsb_bits", 64'(bits_b[7:0]), 64'h80);

      // Sender-style stream of six bytes paced by Empty
      n0 = na;
      for (int i = 0; i < 6; i++) begin
         wait_a_empty("msg_wait_empty");
         load_a(msg[i]);
      end
      wait_a_idle("msg_wait_idle");
      chk("msg_nbits", 64'(na - n0), 64'd48);
      chk("msg_bits", 64'(bits_a[47:0]), 64'hDEADBEEF0102);
      chk("msg_ovr", 64'(bus_a.Overrun), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
